// File: rtl/matrix_scan_controller.sv
// matrix_scan_controller
//   Column-scan sequencer for a 5x7 LED matrix that sits behind a
//   combinational map decoder. The controller drives the decoder's map_code
//   and enable inputs. It latches the decoder bitmap once per frame and then
//   scans one column at a time, with a blanking gap before every column.
//   New map codes come in through a valid/ready handshake and are applied
//   only at frame boundaries, so a displayed frame never mixes two maps.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   display_on   1 = scan, 0 = display off
//   code_in      requested map code
//   code_valid   code_in valid this cycle
//   code_ready   a code can be accepted (no code pending)
//   map_code     registered map code to the decoder
//   enable       registered decoder enable
//   frame_in     decoder bitmap, active-low, bit c*COLUNE_SIZE+r = col c, row r
//   rows         registered active-low row drive
//   columns      registered one-hot column select
//   frame_start  one-cycle pulse on the first drive cycle of column 0
//
// DATA_WIDTH must equal COLUNE_SIZE*TOTAL_COLUNES. DWELL_CYCLES and
// BLANK_CYCLES must both be >= 1.

// Per-column lane: decides whether this column is the one being selected
// and presents its row slice. When the lane is not selected it drives all
// ones, so the top can AND the lanes together into a single row word.
module matrix_scan_lane #(
  parameter int COLUNE_SIZE = 7,
  parameter int COL_W       = 3,
  parameter int LANE        = 0
) (
  input  logic [COL_W-1:0]       col_idx,
  input  logic [COLUNE_SIZE-1:0] slice,
  output logic                   hit,
  output logic [COLUNE_SIZE-1:0] lane_rows
);
  assign hit       = (col_idx == COL_W'(LANE));
  assign lane_rows = hit ? slice : '1;
endmodule

module matrix_scan_controller #(
  parameter int DATA_WIDTH    = 35,
  parameter int COLUNE_SIZE   = 7,
  parameter int TOTAL_COLUNES = 5,
  parameter int DWELL_CYCLES  = 1000,
  parameter int BLANK_CYCLES  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     display_on,
  input  logic [2:0]               code_in,
  input  logic                     code_valid,
  output logic                     code_ready,
  output logic [2:0]               map_code,
  output logic                     enable,
  input  logic [DATA_WIDTH-1:0]    frame_in,
  output logic [COLUNE_SIZE-1:0]   rows,
  output logic [TOTAL_COLUNES-1:0] columns,
  output logic                     frame_start
);

  localparam int COL_W   = (TOTAL_COLUNES > 1) ? $clog2(TOTAL_COLUNES) : 1;
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {S_OFF, S_BLANK, S_DRIVE} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [COL_W-1:0]        col_idx;
  logic [DATA_WIDTH-1:0]   frame_reg;
  logic [2:0]              pending_code;
  logic                    pending_valid;

  logic                    accept;
  logic                    last_col;
  logic [DATA_WIDTH-1:0]   frame_src;
  logic [TOTAL_COLUNES-1:0]                  col_hit;
  logic [TOTAL_COLUNES-1:0][COLUNE_SIZE-1:0] lane_rows;
  logic [COLUNE_SIZE-1:0]  drive_rows;

  assign code_ready = !pending_valid;
  assign accept     = code_valid && !pending_valid;
  assign last_col   = (col_idx == COL_W'(TOTAL_COLUNES-1));

  // Column 0 captures frame_in on the same edge it starts driving, so its
  // rows must come straight from frame_in rather than the stale frame_reg.
  assign frame_src = (col_idx == '0) ? frame_in : frame_reg;

  for (genvar g = 0; g < TOTAL_COLUNES; g++) begin : g_lane
    matrix_scan_lane #(
      .COLUNE_SIZE (COLUNE_SIZE),
      .COL_W       (COL_W),
      .LANE        (g)
    ) u_lane (
      .col_idx   (col_idx),
      .slice     (frame_src[g*COLUNE_SIZE +: COLUNE_SIZE]),
      .hit       (col_hit[g]),
      .lane_rows (lane_rows[g])
    );
  end

  always_comb begin
    drive_rows = '1;
    for (int i = 0; i < TOTAL_COLUNES; i++)
      drive_rows = drive_rows & lane_rows[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_OFF;
      cnt           <= '0;
      col_idx       <= '0;
      frame_reg     <= '1;
      pending_code  <= '0;
      pending_valid <= 1'b0;
      map_code      <= '0;
      enable        <= 1'b0;
      columns       <= '0;
      rows          <= '1;
      frame_start   <= 1'b0;
    end else begin
      frame_start <= 1'b0;

      // Accept and boundary-apply are mutually exclusive: one needs
      // pending_valid low, the other needs it high.
      if (accept) begin
        pending_code  <= code_in;
        pending_valid <= 1'b1;
      end

      case (state)
        S_OFF: begin
          columns <= '0;
          rows    <= '1;
          enable  <= 1'b0;
          // Nothing is on screen, so a pending code can be applied at once.
          if (pending_valid) begin
            map_code      <= pending_code;
            pending_valid <= 1'b0;
          end
          if (display_on) begin
            state   <= S_BLANK;
            col_idx <= '0;
            cnt     <= CNT_W'(BLANK_CYCLES-1);
            enable  <= 1'b1;
          end
        end

        S_BLANK: begin
          if (!display_on) begin
            state   <= S_OFF;
            col_idx <= '0;
            cnt     <= '0;
            enable  <= 1'b0;
            columns <= '0;
            rows    <= '1;
          end else if (cnt == '0) begin
            state   <= S_DRIVE;
            cnt     <= CNT_W'(DWELL_CYCLES-1);
            columns <= col_hit;
            rows    <= drive_rows;
            if (col_idx == '0) begin
              frame_reg   <= frame_in;
              frame_start <= 1'b1;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        S_DRIVE: begin
          if (!display_on) begin
            state   <= S_OFF;
            col_idx <= '0;
            cnt     <= '0;
            enable  <= 1'b0;
            columns <= '0;
            rows    <= '1;
          end else if (cnt == '0) begin
            state   <= S_BLANK;
            cnt     <= CNT_W'(BLANK_CYCLES-1);
            columns <= '0;
            rows    <= '1;
            if (last_col) begin
              // Frame boundary: the new code lands in the first blank cycle
              // so the decoder output settles before the next capture.
              col_idx <= '0;
              if (pending_valid) begin
                map_code      <= pending_code;
                pending_valid <= 1'b0;
              end
            end else begin
              col_idx <= col_idx + COL_W'(1);
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        default: begin
          state   <= S_OFF;
          col_idx <= '0;
          cnt     <= '0;
          enable  <= 1'b0;
          columns <= '0;
          rows    <= '1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_scan_controller.sv
module tb_matrix_scan_controller;
  localparam int DW = 35, CS = 7, TC = 5, DWELL = 4, BLANK = 2;

  logic          clk, reset, display_on, code_valid, code_ready, enable, frame_start;
  logic [2:0]    code_in, map_code;
  logic [DW-1:0] frame_in;
  logic [CS-1:0] rows;
  logic [TC-1:0] columns;

  typedef logic [TC-1:0][CS-1:0] pat_t;
  typedef struct {
    int    cyc;
    string name;
    int    cols;
    int    rws;
    int    en;
    int    mc;
    int    rdy;
    int    fs;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  pat_t p1, p2, p3;

  matrix_scan_controller #(
    .DATA_WIDTH(DW), .COLUNE_SIZE(CS), .TOTAL_COLUNES(TC),
    .DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK)
  ) dut (
    .clk(clk), .reset(reset), .display_on(display_on),
    .code_in(code_in), .code_valid(code_valid), .code_ready(code_ready),
    .map_code(map_code), .enable(enable), .frame_in(frame_in),
    .rows(rows), .columns(columns), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(int c, string n, int co, int ro, int en, int mc, int rdy, int fs);
    exp_t e;
    e.cyc = c; e.name = n; e.cols = co; e.rws = ro;
    e.en = en; e.mc = mc; e.rdy = rdy; e.fs = fs;
    sb.push_back(e);
  endtask

  task automatic push_off(int c, string n, int mc, int rdy);
    push(c, n, 0, 'h7F, 0, mc, rdy, 0);
  endtask

  task automatic push_ctl(int a, int b, int mc, int rdy);
    for (int c = a; c <= b; c++) push(c, "ctl", -1, -1, -1, mc, rdy, -1);
  endtask

  task automatic push_frame(int b, pat_t p, int n, string nm);
    for (int i = 0; i < n; i++) begin
      int c, ph;
      c  = i / 6;
      ph = i % 6;
      if (ph < 2) push(b + i, nm, 0, 'h7F, 1, -1, -1, 0);
      else        push(b + i, nm, 1 << c, int'(p[c]), 1, -1, -1, (c == 0 && ph == 2) ? 1 : 0);
    end
  endtask

  task automatic wait_to(int c);
    while (cyc < c) @(negedge clk);
  endtask

  function automatic bit fld_ok(int e, int a);
    return (e < 0) || (e == a);
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        exp_t e;
        bit   ok;
        e  = sb[i];
        ok = (e.cyc == cyc) &&
             fld_ok(e.cols, int'(columns)) && fld_ok(e.rws, int'(rows)) &&
             fld_ok(e.en, int'(enable)) && fld_ok(e.mc, int'(map_code)) &&
             fld_ok(e.rdy, int'(code_ready)) && fld_ok(e.fs, int'(frame_start));
        total++;
        if (!ok) begin
          bad++;
          $display("FAIL %s cyc=%0d(due %0d) got cols=%b rows=%h en=%b mc=%0d rdy=%b fs=%b expected cols=%0d rows=%0d en=%0d mc=%0d rdy=%0d fs=%0d",
                   e.name, cyc, e.cyc, columns, rows, enable, map_code, code_ready, frame_start,
                   e.cols, e.rws, e.en, e.mc, e.rdy, e.fs);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    p1 = 35'h7_FFFF_FFFE;
    p2 = {7'h10, 7'h08, 7'h04, 7'h02, 7'h01};
    p3 = {7'h7F, 7'h55, 7'h2A, 7'h00, 7'h3C};

    reset = 1'b1; display_on = 1'b0; code_valid = 1'b0; code_in = 3'd0; frame_in = p1;
    push_off(1, "reset", 0, 1);
    push_off(2, "reset", 0, 1);

    wait_to(2);
    total++;
    if (columns !== 5'b00000) begin bad++; $display("FAIL rst columns=%b", columns); end
    total++;
    if (rows !== 7'h7F) begin bad++; $display("FAIL rst rows=%h", rows); end
    total++;
    if (enable !== 1'b0) begin bad++; $display("FAIL rst enable=%b", enable); end
    total++;
    if (map_code !== 3'd0) begin bad++; $display("FAIL rst map_code=%0d", map_code); end
    total++;
    if (code_ready !== 1'b1) begin bad++; $display("FAIL rst code_ready=%b", code_ready); end
    total++;
    if (frame_start !== 1'b0) begin bad++; $display("FAIL rst frame_start=%b", frame_start); end
    reset = 1'b0;
    push_off(3, "off_idle", 0, 1);

    wait_to(3);
    display_on = 1'b1;
    push_frame(4, p1, 30, "frame1");
    push_ctl(4, 18, 0, 1);

    wait_to(18);
    code_valid = 1'b1; code_in = 3'd5;
    push_ctl(19, 33, 0, 0);
    push_ctl(34, 34, 5, 1);

    wait_to(19);
    code_in = 3'd6;
    push_ctl(35, 63, 5, 0);
    push_ctl(64, 84, 6, 1);

    wait_to(20);
    frame_in = p2;
    push_frame(34, p2, 30, "frame2");

    wait_to(35);
    code_valid = 1'b0;

    wait_to(50);
    frame_in = p3;
    push_frame(64, p3, 21, "frame3");

    wait_to(84);
    display_on = 1'b0;
    push_off(85, "disp_off", 6, 1);

    wait_to(85);
    code_valid = 1'b1; code_in = 3'd2;
    push_off(86, "off_code", 6, 0);
    push_off(87, "off_code", 2, 1);
    push_off(88, "off_code", 2, 1);

    wait_to(86);
    code_valid = 1'b0;

    wait_to(88);
    display_on = 1'b1;
    push_frame(89, p3, 10, "frame4");
    push_ctl(89, 97, 2, 1);

    wait_to(97);
    code_valid = 1'b1; code_in = 3'd3;
    push_ctl(98, 98, 2, 0);

    wait_to(98);
    code_valid = 1'b0; reset = 1'b1; display_on = 1'b0;
    push_off(99, "reset_mid", 0, 1);

    wait_to(99);
    reset = 1'b0;
    push_off(100, "post_reset", 0, 1);
    push_off(101, "post_reset", 0, 1);

    wait_to(104);
    while (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL %s never checked, due cyc=%0d", sb[0].name, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/matrix_scan_controller.md
# matrix_scan_controller

Column-scan sequencer for the 5x7 LED matrix fed by the map decoder. It owns the decoder's `map_code` and `enable` inputs, and latches the decoder's 35-bit bitmap once per frame. It then drives one column at a time, with a blanking gap between columns to prevent ghosting. New map codes arrive through a valid/ready handshake and take effect only at frame boundaries, so a displayed frame is never torn.

## Interface
- `DATA_WIDTH`, 35: bitmap width; must equal `COLUNE_SIZE*TOTAL_COLUNES`.
- `COLUNE_SIZE`, 7: rows per column.
- `TOTAL_COLUNES`, 5: columns.
- `DWELL_CYCLES`, 1000: clock cycles each column is driven; must be >= 1.
- `BLANK_CYCLES`, 16: clock cycles of blanking before each column; must be >= 1.
- `clk`  in  1  single system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `display_on`  in  1  level signal; 1 = scanning, 0 = display off.
- `code_in`  in  3  requested map code.
- `code_valid`  in  1  `code_in` is valid this cycle.
- `code_ready`  out  1  controller can accept a code; equals `!pending_valid`.
- `map_code`  out  3  registered; drives the decoder's `map_code`.
- `enable`  out  1  registered; drives the decoder's `enable`.
- `frame_in`  in  DATA_WIDTH  decoder's `mapOut` (active-low bitmap; bit c*7+r = column c, row r).
- `rows`  out  COLUNE_SIZE  registered, active-low row drive (0 = LED lit).
- `columns`  out  TOTAL_COLUNES  registered, one-hot active-high column select.
- `frame_start`  out  1  registered; 1-cycle pulse on the first drive cycle of column 0.

## Operation
- **States:** OFF, BLANK, DRIVE. A down-counter `cnt` times the BLANK and DRIVE states. `col_idx` ranges 0..TOTAL_COLUNES-1.
- **OFF:**
  - `columns`=0, `rows`=all 1s, `enable`=0.
  - If `display_on`=1, go to BLANK with `col_idx`=0 and `cnt`=BLANK_CYCLES-1, and set `enable`=1.
- **BLANK:**
  - `columns`=0, `rows`=all 1s.
  - When `cnt`=0, go to DRIVE with `cnt`=DWELL_CYCLES-1.
  - If `col_idx`=0, `frame_reg` captures `frame_in` on that same last blank cycle.
- **DRIVE:**
  - `columns`=1<<`col_idx`.
  - `rows`=`frame_reg[col_idx*7 +: 7]`.
  - When `cnt`=0, go to BLANK with `cnt`=BLANK_CYCLES-1.
  - `col_idx` increments; the increment after the last column wraps it to 0 (this is the frame boundary).
- **Frame boundary:** if `pending_valid`=1, then `map_code` takes `pending_code` and `pending_valid` clears. This happens on the same edge as the BLANK entry.
- **Handshake:**
  - A code is accepted when `code_valid && code_ready`: `pending_code`<=`code_in`, `pending_valid`<=1.
  - While `pending_valid`=1, `code_ready`=0 and `code_in` is ignored.
  - A code accepted in the boundary cycle itself is applied at the next boundary; the boundary logic only sees `pending_valid` as registered at the start of the cycle.
- **OFF with a pending code:** the code is applied one cycle after acceptance. `code_ready` returns to 1 on the following cycle.
- **`display_on`=0 in BLANK or DRIVE:** next edge goes to OFF with `col_idx`=0 and `enable`=0. The partial frame is abandoned and no boundary update occurs.
- **`frame_start`:** pulses exactly once per frame, on the first DRIVE cycle with `col_idx`=0.

## Timing
- **Reset values:**
  - State and counters: state=OFF, `cnt`=0, `col_idx`=0.
  - Outputs: `map_code`=0, `enable`=0, `columns`=0, `rows`=all 1s, `frame_start`=0.
  - Handshake and frame: `pending_valid`=0, so `code_ready`=1; `frame_reg`=all 1s.
- **Reset mid-operation:** same values on the next edge; `pending_code` is discarded.
- **Per-column timing:**
  - Blanking lasts exactly BLANK_CYCLES cycles.
  - Drive lasts exactly DWELL_CYCLES cycles.
  - Frame period = TOTAL_COLUNES*(BLANK_CYCLES+DWELL_CYCLES).
- **`display_on` latency:** 1 cycle from `display_on` rising (sampled in OFF) to the first BLANK cycle. Column 0 drives BLANK_CYCLES cycles later.
- **Code latency:** a new `map_code` appears in the first BLANK cycle of the new frame. The decoder is combinational, so `frame_in` settles before the capture in the last blank cycle (guaranteed because BLANK_CYCLES >= 1).
- `rows`/`columns` never change within a DRIVE dwell; all transitions occur through blanking.

## Test plan
Bench uses DWELL_CYCLES=4, BLANK_CYCLES=2, with the real decoder or a stubbed `frame_in`.

1. **Reset:** assert `reset` for 2 cycles.
   -> `columns`=0, `rows`=7'h7F, `enable`=0, `map_code`=0, `code_ready`=1, `frame_start`=0.
2. **Scan order:** `display_on`=1, stub `frame_in`=35'h7_FFFF_FFFE.
   -> 1 OFF cycle, 2 blank cycles, then `columns`=5'b00001 with `rows`=7'h7E for 4 cycles and `frame_start` high on the first of them.
   -> Then 2 blank cycles, then `columns`=5'b00010 with `rows`=7'h7F.
   -> Full period is 30 cycles.
3. **Handshake:** offer code 3'd5 during column 2 drive.
   -> Accepted that cycle; `code_ready`=0 next cycle.
   -> `map_code` stays 0 through column 4 and becomes 5 in the first following blank cycle; `code_ready`=1 from that cycle.
4. **Back-pressure:** hold `code_valid` with 3'd6 while pending=5.
   -> Not accepted until `code_ready` returns.
   -> `map_code` becomes 5 at the first boundary and 6 at the next.
5. **Display off mid-column:** drop `display_on` in column 3 drive.
   -> Next cycle `columns`=0, `rows`=7'h7F, `enable`=0.
   -> Code 3'd2 accepted while OFF gives `map_code`=2 one cycle later.
6. **Reset mid-drive:** `reset` for 1 cycle during column 1 drive with a code pending.
   -> All reset values return; `map_code`=0 and the pending code is lost.
